mem_pipe: RTL and testbench
===========================

# mem_pipe

Parametrised simple-dual-port RAM with a true pipelined read latency, a read-valid strobe, byte-enable writes and a hardware clear sequencer. It is the next-generation local storage for the processor datapath: register-file backing, scratch buffers and instruction/data staging. It replaces the combinational-read memory.

## Interface
- `N`, default 256: depth in words; any value ≥ 2, not necessarily a power of 2.
- `M`, default 32: data width; must be a multiple of 8.
- `LATENCY`, default 2: read latency in cycles; ≥ 1.
- `AW`, derived as `$clog2(N)`: address width.
- `BW`, derived as `M/8`: byte-enable width.

Ports:
- `clk`  in  1  the single clock; all state is on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  write request.
- `wr_addr`  in  AW  write address.
- `wr_data`  in  M  write data.
- `wr_be`  in  BW  byte enables; bit i covers `wr_data[8i+7:8i]`.
- `rd_en`  in  1  read request.
- `rd_addr`  in  AW  read address.
- `rd_data`  out  M  read data; reset value 0.
- `rd_valid`  out  1  `rd_data` is valid this cycle; reset value 0.
- `clr_req`  in  1  start a whole-array clear.
- `busy`  out  1  clear in progress; reset value 0.

## Operation
- **FSM states:** IDLE and CLEAR, with a clear pointer `clr_ptr` (AW bits).
- **IDLE → CLEAR:** on `clr_req` while in IDLE. `clr_ptr` is loaded with 0.
- **CLEAR:** each cycle writes 0 to `mem[clr_ptr]` and increments `clr_ptr`. After writing N−1, the FSM returns to IDLE.
- **`busy`:** equals (state == CLEAR).
- **Writes:** accepted when `wr_en` && !`busy` && !`clr_req`. Only the bytes with `wr_be` set are updated; `wr_be` == 0 is a no-op.
- **Reads:** accepted when `rd_en` && !`busy` && !`clr_req`. The read captures the array word in the acceptance cycle and enters a LATENCY-deep valid/data pipeline.
- **Dropped requests:** `clr_req` dominates same-cycle `wr_en`/`rd_en`; both are dropped. Requests while `busy` are dropped silently.
- **`clr_req` during CLEAR:** ignored; no restart.
- **Out-of-range addresses** (addr ≥ N, possible when N is not a power of 2): writes are ignored. Reads still produce `rd_valid` with `rd_data` = 0.
- **Reads in flight at clear start:** complete normally with their captured data.
- **`rd_data` when `rd_valid` is 0:** forced to 0.
- **Reset:** asynchronous; returns the FSM to IDLE, `clr_ptr` to 0, and zeroes all pipeline valid/data stages. Array contents are not reset. Reset mid-CLEAR leaves the array partially cleared; this is legal.

## Timing
- Read accepted in cycle t → `rd_valid` = 1 and data in cycle t+LATENCY.
- One read per cycle, fully pipelined, with no bubbles.
- A write accepted in cycle t is visible to reads accepted in t+1 and later.
- A same-cycle, same-address read/write is governed by `MEM_BYPASS_EN`.
- `clr_req` in cycle t → `busy` high from t+1 through t+N inclusive. Normal requests are accepted again from t+N+1.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `MEM_BYPASS_EN` defined: write-first forwarding. A same-cycle read of the written address returns the merged word: bytes with `wr_be` set come from `wr_data`, the remainder from the old array contents.
- `MEM_BYPASS_EN` undefined: read-first. A same-cycle read returns the old array contents.
- Forwarding never applies to out-of-range or dropped writes.

## Structure
- Package `mem_pkg`:
  - `mem_state_e` (IDLE, CLEAR).
  - Helper function `be_merge(old, new, be)`, shared by the write path and the bypass path.
  - Elaboration-time check constants for legal `M`/`LATENCY`.
- Sub-module `mem_delay_line`:
  - Parameters: width, depth.
  - A LATENCY-stage register chain carrying {valid, data}, with asynchronous active-high clear.
  - Instantiated once for the read path.
- The top level holds the array, FSM, request arbitration and bypass mux.

## Test plan
- **Reset/idle:** assert `rst` mid-run → `rd_valid`=0, `rd_data`=0, `busy`=0 immediately (asynchronous).
- **Latency:** N=256, M=32, LATENCY=3.
  - Write 0xDEADBEEF @5 at cycle 0.
  - `rd_en` @5 at cycle 1 → `rd_valid`=1 with 0xDEADBEEF at cycle 4.
  - Back-to-back reads @0..7 return in order at consecutive cycles.
- **Byte enables:** @9 holds 0x11223344; write 0xAABBCCDD with `wr_be`=4'b0101 → read returns 0x11BB33DD.
- **Same-cycle collision** (write 0x55 @3, old 0x77, same-cycle read @3):
  - With `MEM_BYPASS_EN` → 0x55.
  - Without → 0x77.
- **Clear:**
  - `clr_req` at cycle t with concurrent write → write dropped.
  - `busy` high for cycles t+1..t+N.
  - `rd_en` during `busy` → no `rd_valid`.
  - Afterwards every address reads 0.
  - A second `clr_req` mid-clear → no extension of `busy`.
- **Non-power-of-2:** N=100.
  - Write @120 → no effect on any address.
  - Read @120 → `rd_valid`=1, `rd_data`=0.
  - Reset during CLEAR at `clr_ptr`=40 → `busy`=0 next cycle; addresses 40..99 retain their old data.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types, limits and helpers for the pipelined RAM (mem_pipe).
// MEM_BYPASS_EN selects write-first forwarding in mem_pipe.
package mem_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } mem_state_e;

    // Widest word be_merge can handle; callers widen into it and truncate back.
    localparam int MAX_W  = 512;
    localparam int MAX_BW = MAX_W / 8;

    function automatic bit width_legal(input int m);
        return (m >= 8) && (m % 8 == 0) && (m <= MAX_W);
    endfunction

    function automatic bit latency_legal(input int lat);
        return lat >= 1;
    endfunction

    function automatic logic [MAX_W-1:0] be_merge(
        input logic [MAX_W-1:0]  old_word,
        input logic [MAX_W-1:0]  new_word,
        input logic [MAX_BW-1:0] be
    );
        logic [MAX_W-1:0] merged;
        merged = old_word;
        for (int i = 0; i < MAX_BW; i++) begin
            if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/mem_delay_line.sv
// Fixed-depth register chain carrying {valid, data} for the read pipeline.
module mem_delay_line #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/mem_pipe.sv
// Simple-dual-port RAM with pipelined reads, byte-enable writes and a clear sequencer.
// Define MEM_BYPASS_EN for write-first same-address forwarding; default is read-first.
module mem_pipe
    import mem_pkg::*;
#(
    parameter int N       = 256,
    parameter int M       = 32,
    parameter int LATENCY = 2,
    parameter int AW      = $clog2(N),
    parameter int BW      = M / 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [M-1:0]  wr_data,
    input  logic [BW-1:0] wr_be,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [M-1:0]  rd_data,
    output logic          rd_valid,
    input  logic          clr_req,
    output logic          busy
);

    if (!width_legal(M) || !latency_legal(LATENCY) || N < 2) begin : g_bad_cfg
        $error("mem_pipe: illegal N/M/LATENCY");
    end

    localparam logic [AW:0]   N_LIM    = (AW+1)'(N);
    localparam logic [AW-1:0] LAST_PTR = AW'(N - 1);

    mem_state_e       state;
    logic [AW-1:0]    clr_ptr;
    logic [M-1:0]     mem [N];
    logic             accept;
    logic             wr_ok;
    logic             rd_ok;
    logic [M-1:0]     wr_merged;
    logic [M-1:0]     rd_word;
    logic [M:0]       pipe_in;
    logic [M:0]       pipe_out;

    // clr_req wins over same-cycle traffic; out-of-range writes never land.
    assign accept    = (state == IDLE) && !clr_req;
    assign wr_ok     = wr_en && accept && ({1'b0, wr_addr} < N_LIM);
    assign rd_ok     = rd_en && accept;
    assign busy      = (state == CLEAR);
    assign wr_merged = M'(be_merge(MAX_W'(mem[wr_addr]), MAX_W'(wr_data), MAX_BW'(wr_be)));

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            clr_ptr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state   <= CLEAR;
                        clr_ptr <= '0;
                    end
                end
                CLEAR: begin
                    if (clr_ptr == LAST_PTR) begin
                        state   <= IDLE;
                        clr_ptr <= '0;
                    end else begin
                        clr_ptr <= clr_ptr + AW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the array has no reset; clearing it is the sequencer's job, not rst's.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_ptr] <= '0;
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_merged;
        end
    end

    // NOTE: rd_word gets a default before any branch so no latch is inferred.
    always_comb begin
        rd_word = '0;
        if ({1'b0, rd_addr} < N_LIM) rd_word = mem[rd_addr];
`ifdef MEM_BYPASS_EN
        if (wr_ok && (wr_addr == rd_addr)) rd_word = wr_merged;
`else
`endif
    end

    assign pipe_in = {rd_ok, rd_ok ? rd_word : {M{1'b0}}};

    mem_delay_line #(
        .WIDTH (M + 1),
        .DEPTH (LATENCY)
    ) u_rd_pipe (
        .clk (clk),
        .rst (rst),
        .d   (pipe_in),
        .q   (pipe_out)
    );

    assign rd_valid = pipe_out[M];
    assign rd_data  = pipe_out[M-1:0];

endmodule

// File: tb/tb_mem_pipe.sv
// Scoreboard bench for mem_pipe: a 256-word and a 100-word instance share all inputs.
module tb_mem_pipe;

    localparam int LAT = 3;
    localparam int N_A = 256;
    localparam int N_B = 100;

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en, rd_en, clr_req;
    logic [7:0]  wr_addr, rd_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;

    logic [31:0] rd_data_a, rd_data_b;
    logic        rd_valid_a, rd_valid_b, busy_a, busy_b;

    logic [31:0] rd_exp_a, rd_exp_b;
    exp_t        q_a[$];
    exp_t        q_b[$];
    int          busy_left_a = 0;
    int          busy_left_b = 0;
    int          edge_cnt = 0;
    int          n_cmp = 0;
    int          n_fail = 0;

`ifdef MEM_BYPASS_EN
    localparam logic [31:0] COLL_FULL = 32'h0000_0055;
    localparam logic [31:0] COLL_PART = 32'h0000_5678;
`else
    localparam logic [31:0] COLL_FULL = 32'h0000_0077;
    localparam logic [31:0] COLL_PART = 32'h0000_0055;
`endif

    always #5 clk = ~clk;

    mem_pipe #(.N(N_A), .M(32), .LATENCY(LAT)) dut_a (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_be    (wr_be),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data_a),
        .rd_valid (rd_valid_a),
        .clr_req  (clr_req),
        .busy     (busy_a)
    );

    mem_pipe #(.N(N_B), .M(32), .LATENCY(LAT)) dut_b (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr[6:0]),
        .wr_data  (wr_data),
        .wr_be    (wr_be),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr[6:0]),
        .rd_data  (rd_data_b),
        .rd_valid (rd_valid_b),
        .clr_req  (clr_req),
        .busy     (busy_b)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (edge %0d)", tag, observed, expected, edge_cnt);
        end
    endtask

    task automatic check_port(input int idx, input logic v, input logic [31:0] d, input logic b);
        exp_t  e;
        bit    have;
        int    bl;
        string tag;
        have = 1'b0;
        e    = '{due: 0, data: 32'h0};
        if (idx == 0) begin
            tag = "a";
            bl  = busy_left_a;
            if (q_a.size() > 0 && q_a[0].due == edge_cnt) begin
                have = 1'b1;
                e    = q_a.pop_front();
            end
        end else begin
            tag = "b";
            bl  = busy_left_b;
            if (q_b.size() > 0 && q_b[0].due == edge_cnt) begin
                have = 1'b1;
                e    = q_b.pop_front();
            end
        end
        check({tag, ".rd_valid"}, {31'b0, v}, {31'b0, have});
        check({tag, ".rd_data"}, d, have ? e.data : 32'h0);
        check({tag, ".busy"}, {31'b0, b}, {31'b0, (bl > 0)});
    endtask

    // One clock: record expectations for what is being driven, then check outputs.
    task automatic tick();
        if (rd_en && busy_left_a == 0 && !clr_req) q_a.push_back('{due: edge_cnt + LAT, data: rd_exp_a});
        if (rd_en && busy_left_b == 0 && !clr_req) q_b.push_back('{due: edge_cnt + LAT, data: rd_exp_b});
        if (busy_left_a > 0) busy_left_a--; else if (clr_req) busy_left_a = N_A;
        if (busy_left_b > 0) busy_left_b--; else if (clr_req) busy_left_b = N_B;
        @(posedge clk);
        edge_cnt++;
        @(negedge clk);
        check_port(0, rd_valid_a, rd_data_a, busy_a);
        check_port(1, rd_valid_b, rd_data_b, busy_b);
    endtask

    task automatic set_idle();
        wr_en = 1'b0; wr_addr = 8'h0; wr_data = 32'h0; wr_be = 4'h0;
        rd_en = 1'b0; rd_addr = 8'h0; clr_req = 1'b0;
        rd_exp_a = 32'h0; rd_exp_b = 32'h0;
    endtask

    task automatic do_idle(input int n);
        set_idle();
        repeat (n) tick();
    endtask

    task automatic do_wr(input int a, input logic [31:0] d, input logic [3:0] be);
        set_idle();
        wr_en = 1'b1; wr_addr = 8'(a); wr_data = d; wr_be = be;
        tick();
    endtask

    task automatic do_rd(input int a, input logic [31:0] ea, input logic [31:0] eb);
        set_idle();
        rd_en = 1'b1; rd_addr = 8'(a); rd_exp_a = ea; rd_exp_b = eb;
        tick();
    endtask

    task automatic do_wr_rd(input int wa, input logic [31:0] d, input logic [3:0] be,
                            input int ra, input logic [31:0] e);
        set_idle();
        wr_en = 1'b1; wr_addr = 8'(wa); wr_data = d; wr_be = be;
        rd_en = 1'b1; rd_addr = 8'(ra); rd_exp_a = e; rd_exp_b = e;
        tick();
    endtask

    // Asynchronous reset asserted between edges; outputs must drop at once.
    task automatic do_reset(input string tag);
        set_idle();
        #2 rst = 1'b1;
        #1;
        check({tag, ".a.rd_valid"}, {31'b0, rd_valid_a}, 32'h0);
        check({tag, ".a.rd_data"}, rd_data_a, 32'h0);
        check({tag, ".a.busy"}, {31'b0, busy_a}, 32'h0);
        check({tag, ".b.rd_valid"}, {31'b0, rd_valid_b}, 32'h0);
        check({tag, ".b.rd_data"}, rd_data_b, 32'h0);
        check({tag, ".b.busy"}, {31'b0, busy_b}, 32'h0);
        q_a.delete();
        q_b.delete();
        busy_left_a = 0;
        busy_left_b = 0;
        @(posedge clk);
        edge_cnt++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        set_idle();
        do_reset("reset_init");
        do_idle(2);

        // Latency: write then read the same word the next cycle.
        do_wr(5, 32'hDEAD_BEEF, 4'hF);
        do_rd(5, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        do_idle(4);

        // Back-to-back reads return in order on consecutive cycles.
        for (int i = 0; i < 8; i++) do_wr(i, 32'hC0DE_0000 + 32'(i), 4'hF);
        for (int i = 0; i < 8; i++) do_rd(i, 32'hC0DE_0000 + 32'(i), 32'hC0DE_0000 + 32'(i));
        do_idle(4);

        // Byte enables, including the all-zero no-op.
        do_wr(9, 32'h1122_3344, 4'hF);
        do_wr(9, 32'hAABB_CCDD, 4'b0101);
        do_rd(9, 32'h11BB_33DD, 32'h11BB_33DD);
        do_wr(9, 32'hFFFF_FFFF, 4'b0000);
        do_rd(9, 32'h11BB_33DD, 32'h11BB_33DD);

        // Same-cycle collisions (full and partial byte enables) and a non-colliding pair.
        do_wr(3, 32'h0000_0077, 4'hF);
        do_wr_rd(3, 32'h0000_0055, 4'hF, 3, COLL_FULL);
        do_rd(3, 32'h0000_0055, 32'h0000_0055);
        do_wr_rd(3, 32'h1234_5678, 4'b0011, 3, COLL_PART);
        do_rd(3, 32'h0000_5678, 32'h0000_5678);
        do_wr_rd(4, 32'h0000_0099, 4'hF, 9, 32'h11BB_33DD);
        do_rd(4, 32'h0000_0099, 32'h0000_0099);
        do_idle(4);

        // Address 120 is real storage in the 256-word part, out of range in the 100-word part.
        do_wr(20, 32'h2020_2020, 4'hF);
        do_wr(120, 32'hCAFE_F00D, 4'hF);
        do_rd(120, 32'hCAFE_F00D, 32'h0);
        do_rd(20, 32'h2020_2020, 32'h2020_2020);
        do_idle(4);

        // Reset with reads in flight kills them; array contents survive.
        for (int i = 0; i < 6; i++) do_rd(20, 32'h2020_2020, 32'h2020_2020);
        do_reset("reset_inflight");
        do_idle(4);
        do_rd(20, 32'h2020_2020, 32'h2020_2020);
        do_idle(4);

        // Fill, start a clear with a concurrent write/read, reset at clr_ptr = 40.
        for (int i = 0; i < N_B; i++) do_wr(i, 32'hA500_0000 | 32'(i), 4'hF);
        set_idle();
        clr_req = 1'b1;
        wr_en = 1'b1; wr_addr = 8'd60; wr_data = 32'h0000_0BAD; wr_be = 4'hF;
        rd_en = 1'b1; rd_addr = 8'd1;
        tick();
        for (int i = 0; i < 10; i++) do_rd(2, 32'h0, 32'h0);
        do_idle(30);
        do_reset("reset_midclear");
        do_idle(1);
        for (int i = 38; i < N_B; i++) begin
            do_rd(i, (i < 40) ? 32'h0 : (32'hA500_0000 | 32'(i)),
                     (i < 40) ? 32'h0 : (32'hA500_0000 | 32'(i)));
        end
        do_idle(4);

        // Full clear with reads hammering throughout and a second clr_req mid-clear.
        set_idle();
        clr_req = 1'b1;
        tick();
        for (int j = 1; j <= 300; j++) begin
            set_idle();
            rd_en = 1'b1;
            rd_addr = 8'(j);
            clr_req = (j == 50);
            tick();
        end
        for (int i = 0; i < N_A; i++) do_rd(i, 32'h0, 32'h0);
        do_idle(LAT + 2);

        check("drain_a", 32'(q_a.size()), 32'h0);
        check("drain_b", 32'(q_b.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
